// File: rtl/rf_issue_sched_pkg.sv
// rf_sched_pkg: shared types and helpers for the register-file issue scheduler.
//   - calc_addr_w      : address width from stack geometry
//   - stack_field /
//     cell_field       : split an address into its stack and cell parts
//   - stage_t          : {valid, vec, addr} record for the issue and writeback stages
//   - lane_sel         : per-lane select address for a scalar or vector op
//   - overlap          : coverage test between a read operand and a pending write
// Addresses travel as addr_t (ADDR_W_MAX bits); only the low ADDR_W bits are
// meaningful and the rest stay zero.
package rf_sched_pkg;

  localparam int ADDR_W_MAX = 16;

  typedef logic [ADDR_W_MAX-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    logic  vec;
    addr_t addr;
  } stage_t;

  function automatic int calc_addr_w(input int stack_num, input int stack_size);
    return $clog2(stack_num * stack_size);
  endfunction

  function automatic addr_t field_mask(input int addr_w);
    return addr_t'((32'd1 << (addr_w / 2)) - 32'd1);
  endfunction

  function automatic addr_t stack_field(input addr_t a, input int addr_w);
    return (a >> (addr_w / 2)) & field_mask(addr_w);
  endfunction

  function automatic addr_t cell_field(input addr_t a, input int addr_w);
    return a & field_mask(addr_w);
  endfunction

  // Scalar ops use lane 0 only; idle lanes read address 0.
  // Vector ops walk every cell of the addressed stack, one per lane.
  function automatic addr_t lane_sel(input addr_t a, input logic vec, input int lane,
                                     input int addr_w);
    if (vec)
      return (stack_field(a, addr_w) << (addr_w / 2)) | addr_t'(lane);
    else if (lane == 0)
      return cell_field(a, addr_w) | (stack_field(a, addr_w) << (addr_w / 2));
    else
      return '0;
  endfunction

  // A vector address covers its whole stack, so any vector on either side
  // reduces the test to a stack-field compare.
  function automatic logic overlap(input addr_t rd, input logic rd_vec,
                                   input addr_t wr, input logic wr_vec, input int addr_w);
    if (rd_vec || wr_vec)
      return stack_field(rd, addr_w) == stack_field(wr, addr_w);
    else
      return rd == wr;
  endfunction

endpackage

// File: rtl/rf_wb_pipe.sv
// rf_wb_pipe: fixed-depth delay line of stage_t records carrying issued ops to
// writeback. Every stage is exposed so the hazard logic can see all pending writes.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low clear (drops all pending writes)
//   in_stage  in   record entering stage 0 (the issue register)
//   stages    out  all stages; stages[depth-1] is the one writing back
module rf_wb_pipe
  import rf_sched_pkg::*;
#(
  parameter int depth = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  stage_t               in_stage,
  output stage_t [depth-1:0]   stages
);

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_stage
      stage_t q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= in_stage;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
      assign stages[gi] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/rf_issue_sched.sv
// rf_issue_sched: issue/writeback sequencer for the stacked register file.
// Accepts one scalar or vector op per handshake, drives per-lane read selects in
// the issue cycle and per-lane write selects/enables exec_lat cycles later.
// Optional feature macro: RF_SCHED_SCOREBOARD_EN -- when defined, requests whose
// operands overlap a write still in flight are stalled (RAW hazard).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_vec                1 = vector op
//   req_a, req_b, req_c    operand/destination addresses
//   sel_a, sel_b           per-lane read selects, valid while rd_valid
//   sel_c, wr_en           per-lane write selects and enables at writeback
//   rd_valid               issue strobe
//   busy                   an op is issued or in flight
module rf_issue_sched
  import rf_sched_pkg::*;
#(
  parameter  int stack_size = 4,
  parameter  int stack_num  = 4,
  parameter  int exec_lat   = 2,
  localparam int ADDR_W     = calc_addr_w(stack_num, stack_size)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_vec,
  input  logic [ADDR_W-1:0]                    req_a,
  input  logic [ADDR_W-1:0]                    req_b,
  input  logic [ADDR_W-1:0]                    req_c,
  output logic [stack_size-1:0][ADDR_W-1:0]    sel_a,
  output logic [stack_size-1:0][ADDR_W-1:0]    sel_b,
  output logic [stack_size-1:0][ADDR_W-1:0]    sel_c,
  output logic [stack_size-1:0]                wr_en,
  output logic                                 rd_valid,
  output logic                                 busy
);

  stage_t                 issue_reg;
  addr_t                  issue_a_reg;
  addr_t                  issue_b_reg;
  logic                   ready_en_reg;
  logic                   accept;
  stage_t [exec_lat-1:0]  stages;
  stage_t                 wb;
  logic [exec_lat-1:0]    pipe_valid;

  assign accept = req_valid && req_ready;

  // ready_en_reg holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      issue_reg    <= '0;
      issue_a_reg  <= '0;
      issue_b_reg  <= '0;
    end else begin
      ready_en_reg    <= 1'b1;
      issue_reg.valid <= accept;
      if (accept) begin
        issue_reg.vec  <= req_vec;
        issue_reg.addr <= addr_t'(req_c);
        issue_a_reg    <= addr_t'(req_a);
        issue_b_reg    <= addr_t'(req_b);
      end
    end
  end

  rf_wb_pipe #(.depth(exec_lat)) u_wb_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_stage (issue_reg),
    .stages   (stages)
  );

  assign wb = stages[exec_lat-1];

  genvar gi;

`ifdef RF_SCHED_SCOREBOARD_EN
  // Pending writes: the issue register plus every pipe stage except the last,
  // whose write lands at this edge, ahead of any new issue.
  logic [exec_lat-1:0] hit;

  assign hit[0] = issue_reg.valid &&
                  (overlap(addr_t'(req_a), req_vec, issue_reg.addr, issue_reg.vec, ADDR_W) ||
                   overlap(addr_t'(req_b), req_vec, issue_reg.addr, issue_reg.vec, ADDR_W));

  generate
    for (gi = 0; gi < exec_lat - 1; gi++) begin : g_hit
      assign hit[gi+1] = stages[gi].valid &&
                         (overlap(addr_t'(req_a), req_vec, stages[gi].addr, stages[gi].vec, ADDR_W) ||
                          overlap(addr_t'(req_b), req_vec, stages[gi].addr, stages[gi].vec, ADDR_W));
    end
  endgenerate

  assign req_ready = ready_en_reg && !(|hit);
`else
  // Without hazard checks only the valid bits and the final stage are consumed.
  logic unused_stage_bits;
  assign unused_stage_bits = ^stages;
  assign req_ready = ready_en_reg;
`endif

  assign rd_valid = issue_reg.valid;

  generate
    for (gi = 0; gi < exec_lat; gi++) begin : g_pv
      assign pipe_valid[gi] = stages[gi].valid;
    end
    for (gi = 0; gi < stack_size; gi++) begin : g_lane
      assign sel_a[gi] = issue_reg.valid ?
                         ADDR_W'(lane_sel(issue_a_reg, issue_reg.vec, gi, ADDR_W)) : '0;
      assign sel_b[gi] = issue_reg.valid ?
                         ADDR_W'(lane_sel(issue_b_reg, issue_reg.vec, gi, ADDR_W)) : '0;
      assign sel_c[gi] = wb.valid ?
                         ADDR_W'(lane_sel(wb.addr, wb.vec, gi, ADDR_W)) : '0;
      assign wr_en[gi] = wb.valid && (wb.vec || (gi == 0));
    end
  endgenerate

  assign busy = issue_reg.valid || (|pipe_valid);

endmodule
